// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with any depth >= 2, optional FWFT read,
// programmable almost flags, occupancy count, flush and sticky errors.
module sync_fifo_ctrl #(
  parameter int BITS   = 32,
  parameter int SIZE   = 16,
  parameter int FWFT   = 0,
  parameter int AF_THR = SIZE - 2,
  parameter int AE_THR = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        p_flush,
  input  logic                        p_write_en,
  input  logic [BITS-1:0]             p_write_data,
  output logic                        p_write_full,
  output logic                        p_write_almost_full,
  input  logic                        p_read_en,
  output logic [BITS-1:0]             p_read_data,
  output logic                        p_read_empty,
  output logic                        p_read_almost_empty,
  output logic [$clog2(SIZE+1)-1:0]   p_level,
  output logic                        p_overflow,
  output logic                        p_underflow
);

  localparam int LW = $clog2(SIZE + 1);
  localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;

  if (SIZE < 2 || AE_THR < 0 || AE_THR >= AF_THR || AF_THR > SIZE)
  begin : g_bad_params
    $fatal(1, "sync_fifo_ctrl: illegal SIZE/AF_THR/AE_THR");
  end

  logic [BITS-1:0] r_mem [SIZE];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_full, r_afull, r_empty, r_aempty;
  logic            r_ovf, r_unf;

  logic            w_rd_acc, w_wr_acc;
  logic            w_ovf_set, w_unf_set;
  logic [PW-1:0]   w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [LW-1:0]   w_level_nxt;

  always_comb begin
    w_rd_acc  = p_read_en && !r_empty && !p_flush;
    w_wr_acc  = p_write_en && (!r_full || w_rd_acc) && !p_flush;
    w_ovf_set = p_write_en && !w_wr_acc && !p_flush;
    w_unf_set = p_read_en && !w_rd_acc && !p_flush;

    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    // explicit wrap keeps non-power-of-two depths correct
    if (w_wr_acc)
      w_wr_ptr_nxt = (r_wr_ptr == PW'(SIZE - 1)) ? '0 : r_wr_ptr + PW'(1);
    if (w_rd_acc)
      w_rd_ptr_nxt = (r_rd_ptr == PW'(SIZE - 1)) ? '0 : r_rd_ptr + PW'(1);

    w_level_nxt = r_level;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase

    if (p_flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_level_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
      r_full   <= (w_level_nxt == LW'(SIZE));
      r_afull  <= (w_level_nxt >= LW'(AF_THR));
      r_empty  <= (w_level_nxt == '0);
      r_aempty <= (w_level_nxt <= LW'(AE_THR));
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_unf_set) r_unf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc)
      r_mem[r_wr_ptr] <= p_write_data;
  end

  if (FWFT != 0) begin : g_fwft
    assign p_read_data = r_empty ? '0 : r_mem[r_rd_ptr];
  end else begin : g_reg
    logic [BITS-1:0] r_rdata;
    always_ff @(posedge clk) begin
      if (rst)
        r_rdata <= '0;
      else if (w_rd_acc)
        r_rdata <= r_mem[r_rd_ptr];
    end
    assign p_read_data = r_rdata;
  end

  assign p_write_full        = r_full;
  assign p_write_almost_full = r_afull;
  assign p_read_empty        = r_empty;
  assign p_read_almost_empty = r_aempty;
  assign p_level             = r_level;
  assign p_overflow          = r_ovf;
  assign p_underflow         = r_unf;

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock FIFO that replaces the dual-clock FIFO wherever producer and consumer share one clock. It generalises depth to any SIZE ≥ 2, including non-power-of-two values. It adds a first-word-fall-through (FWFT) mode, programmable almost-full/almost-empty flags, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags. It sits between pipeline stages and bus adapters inside a single clock domain.

## Interface
- BITS, 32, width of each entry.
- SIZE, 16, number of entries; any integer ≥ 2.
- FWFT, 0, read mode:
  - 0 = registered read, 1-cycle latency.
  - 1 = first-word-fall-through.
- AF_THR, SIZE-2, almost-full threshold: `p_write_almost_full` is high when level ≥ AF_THR.
- AE_THR, 2, almost-empty threshold: `p_read_almost_empty` is high when level ≤ AE_THR.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- p_flush  in  1  synchronous clear of contents bookkeeping.
- p_write_en  in  1  write request.
- p_write_data  in  BITS  write data.
- p_write_full  out  1  level == SIZE.
- p_write_almost_full  out  1  level ≥ AF_THR.
- p_read_en  in  1  read request.
- p_read_data  out  BITS  read data.
- p_read_empty  out  1  level == 0.
- p_read_almost_empty  out  1  level ≤ AE_THR.
- p_level  out  $clog2(SIZE+1)  current occupancy.
- p_overflow  out  1  sticky: a write was rejected.
- p_underflow  out  1  sticky: a read was rejected.

One clock; reset is synchronous and active-high.

## Operation
- Elaboration check: `$fatal` unless SIZE ≥ 2 and 0 ≤ AE_THR < AF_THR ≤ SIZE.
- Storage is SIZE × BITS with write and read pointers in 0..SIZE-1.
  - A pointer wraps explicitly from SIZE-1 to 0; modulo-2^n wrap is not used.
- A read is accepted when p_read_en && !p_read_empty.
- A write is accepted when p_write_en && (!p_write_full || read accepted in the same cycle).
  - Write-at-full with a simultaneous read is legal; level stays SIZE.
- At empty, a simultaneous p_write_en and p_read_en gives: write accepted, read rejected, level becomes 1.
- Level update: +1 on write only, -1 on read only, unchanged when both are accepted or neither is.
- Registered read (FWFT=0):
  - p_read_data loads mem[rd_ptr] on the edge that accepts a read.
  - It holds its value otherwise, including across flush.
- FWFT read (FWFT=1):
  - p_read_data = mem[rd_ptr] whenever p_read_empty is 0; the value is don't-care while empty.
  - An accepted read advances to the next entry on the following cycle.
- p_overflow sets on any cycle with p_write_en high and the write rejected.
- p_underflow sets on any cycle with p_read_en high and the read rejected.
- Both error flags clear only on rst.
- p_flush (rst has priority over it):
  - Zeroes the pointers and level; memory contents are not cleared.
  - Ignores p_write_en and p_read_en in that cycle, and sets no error flags.
  - Does not clear the sticky flags.
- While rst is high, all inputs are ignored.
- Reset values:
  - Pointers and level: 0.
  - p_read_empty 1, p_read_almost_empty 1, p_write_full 0, p_write_almost_full 0.
  - p_overflow 0, p_underflow 0, p_read_data 0.
- rst mid-operation discards all entries; the first accepted write after reset goes to address 0.

## Timing
- Level, pointers and all flags are registered and update on the edge that accepts a transfer.
- No combinational path from any input to any output.
- In FWFT mode, p_read_data depends only on registered state (memory and rd_ptr).
- Write-to-read latency: a write accepted at edge N clears p_read_empty after edge N.
  - FWFT=1: data is valid in cycle N+1.
  - FWFT=0: a read requested in cycle N+1 returns data after edge N+2.
- Full-to-writable latency: a read accepted at edge N clears p_write_full after edge N.
- Throughput: one write and one read per cycle, sustained, at any level.

## Test plan
- SIZE=5, FWFT=0: reset, write 0x11..0x55 on 5 consecutive cycles.
  - p_write_full=1 and p_level=5; at level 3, p_write_almost_full=1.
  - Then read 5: data 0x11..0x55 each one cycle after its request; p_read_empty=1 at the end.
- SIZE=5, full: write 0x66 with p_read_en=1 in the same cycle -> read returns 0x11, level stays 5, p_overflow=0.
  - Next, write without a read -> rejected, p_overflow=1, and it stays 1 through a flush.
- Empty FIFO, p_write_en and p_read_en together with data 0xA5 -> p_underflow=1, p_level=1; a subsequent read returns 0xA5.
- FWFT=1: write 0x77 at edge N -> p_read_empty=0 and p_read_data=0x77 in cycle N+1.
  - Read at N+1 -> p_read_empty=1 after N+2.
- Wrap-around: SIZE=5, 13 interleaved write/read pairs with random data -> output order matches input order; p_level never exceeds 5.
- rst asserted at level 3 (and separately p_flush at level 4) -> p_level=0 and p_read_empty=1 after one edge.
  - The next write/read pair returns the new data, not the stale entries.
